mem_arbiter: RTL

Request scheduler between the pipeline's memory users (instruction fetch, load/store buffer) and the single byte-serial memory controller. It owns a small in-order store buffer so that retired stores no longer stall the pipeline. It picks one transaction at a time for the controller by a fixed priority with hazard checks, and returns results to the right requester. It sits between IF/LSB and the memory controller, and the controller keeps its existing request/done protocol.

---
 rtl/mem_arbiter.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: schedules instruction fetches, loads and buffered stores onto a
// single byte-serial memory controller, one transaction at a time.
//
// Handshakes:
//   if_req / ld_req are levels held by the requester until if_ok / ld_done; a
//     request is not re-accepted in the cycle its completion pulse is high.
//   st_req is accepted (enqueued) when st_ack is low and the buffer has room;
//     st_ack pulses the following cycle and the requester drops st_req then.
//   mc_req is a one-cycle issue pulse; mc_* fields hold until mc_done, a
//     one-cycle completion pulse carrying mc_rdata for reads.
//   With rdy low every register holds, so pulses stretch until rdy returns.
module mem_arbiter #(
  parameter int          SB_DEPTH = 4,
  parameter logic [31:0] IO_BASE  = 32'h30000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        clear,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ok,
  output logic [31:0] if_data,
  output logic [31:0] if_pc,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_type,
  output logic        ld_done,
  output logic [31:0] ld_data,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_type,
  output logic        st_ack,
  output logic        sb_empty,
  output logic        mc_req,
  output logic        mc_we,
  output logic        mc_inst,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_wdata,
  output logic [1:0]  mc_type,
  input  logic        mc_done,
  input  logic [31:0] mc_rdata,
  output logic [1:0]  dbg_state
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(SB_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY_IF = 2'd1;
  localparam logic [1:0] S_BUSY_LD = 2'd2;
  localparam logic [1:0] S_BUSY_ST = 2'd3;

  // Store buffer storage
  logic [31:0]         sb_addr [SB_DEPTH];
  logic [31:0]         sb_data [SB_DEPTH];
  logic [1:0]          sb_type [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_valid;
  logic [PW-1:0]       sb_head;
  logic [PW-1:0]       sb_tail;
  logic [CW-1:0]       sb_count;

  logic [1:0] state;
  logic [1:0] issue_state;
  logic       drop_q;     // result of the in-flight read is to be discarded
  logic       sb_full;
  logic       enq;
  logic       pop;
  logic       addr_hit;
  logic       io_ld;
  logic       ld_live;
  logic       ld_conflict;
  logic       ld_go;
  logic       ld_wait;
  logic       if_go;

  assign sb_full   = (sb_count == FULL_CNT);
  assign sb_empty  = (sb_count == '0);
  assign dbg_state = state;

  // Store enters at the tail when there is room and no ack is outstanding;
  // a full buffer does not enqueue even if it pops this cycle.
  assign enq = rdy && st_req && !st_ack && !sb_full;
  assign pop = rdy && (state == S_BUSY_ST) && mc_done;

  // Load hazard: any buffered store to the same word, or any buffered store
  // at all when the load targets the I/O region (I/O reads have side effects
  // and must observe every older store).
  always_comb begin
    addr_hit = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb_valid[i] && (sb_addr[i][31:2] == ld_addr[31:2])) addr_hit = 1'b1;
    end
  end

  assign io_ld       = (ld_addr[31:16] == IO_BASE[31:16]);
  assign ld_live     = ld_req && !ld_done;
  assign ld_conflict = addr_hit || (io_ld && !sb_empty);
  assign ld_go       = ld_live && !clear && !ld_conflict;
  assign ld_wait     = ld_live && ld_conflict;
  assign if_go       = if_req && !if_ok && !clear;

  // Fixed-priority choice of the next transaction while idle.
  always_comb begin
    issue_state = S_IDLE;
    if (sb_full)          issue_state = S_BUSY_ST;
    else if (ld_go)       issue_state = S_BUSY_LD;
    else if (ld_wait)     issue_state = S_BUSY_ST;
    else if (if_go)       issue_state = S_BUSY_IF;
    else if (!sb_empty)   issue_state = S_BUSY_ST;
  end

  // Store buffer: circular FIFO with pointers, count and per-entry valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_head  <= '0;
      sb_tail  <= '0;
      sb_count <= '0;
      sb_valid <= '0;
      st_ack   <= 1'b0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_addr[i] <= '0;
        sb_data[i] <= '0;
        sb_type[i] <= '0;
      end
    end else if (rdy) begin
      st_ack <= enq;
      if (enq) begin
        sb_addr[sb_tail]  <= st_addr;
        sb_data[sb_tail]  <= st_data;
        sb_type[sb_tail]  <= st_type;
        sb_valid[sb_tail] <= 1'b1;
        sb_tail           <= sb_tail + PW'(1);
      end
      if (pop) begin
        sb_valid[sb_head] <= 1'b0;
        sb_head           <= sb_head + PW'(1);
      end
      case ({enq, pop})
        2'b10:   sb_count <= sb_count + CW'(1);
        2'b01:   sb_count <= sb_count - CW'(1);
        default: sb_count <= sb_count;
      endcase
    end
  end

  // Transaction FSM: issue from IDLE, wait for mc_done, return results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      drop_q   <= 1'b0;
      mc_req   <= 1'b0;
      mc_we    <= 1'b0;
      mc_inst  <= 1'b0;
      mc_addr  <= '0;
      mc_wdata <= '0;
      mc_type  <= '0;
      if_ok    <= 1'b0;
      if_data  <= '0;
      if_pc    <= '0;
      ld_done  <= 1'b0;
      ld_data  <= '0;
    end else if (rdy) begin
      mc_req  <= 1'b0;
      if_ok   <= 1'b0;
      ld_done <= 1'b0;
      if (state == S_IDLE) begin
        if (issue_state != S_IDLE) begin
          state  <= issue_state;
          mc_req <= 1'b1;
          drop_q <= 1'b0;
          case (issue_state)
            S_BUSY_LD: begin
              mc_we    <= 1'b0;
              mc_inst  <= 1'b0;
              mc_addr  <= ld_addr;
              mc_wdata <= '0;
              mc_type  <= ld_type;
            end
            S_BUSY_IF: begin
              mc_we    <= 1'b0;
              mc_inst  <= 1'b1;
              mc_addr  <= if_addr;
              mc_wdata <= '0;
              mc_type  <= 2'b11;
            end
            default: begin
              mc_we    <= 1'b1;
              mc_inst  <= 1'b0;
              mc_addr  <= sb_addr[sb_head];
              mc_wdata <= sb_data[sb_head];
              mc_type  <= sb_type[sb_head];
            end
          endcase
        end
      end else begin
        // A flush only cancels the delivery of read results; stores complete.
        if (clear) drop_q <= 1'b1;
        if (mc_done) begin
          state <= S_IDLE;
          if ((state == S_BUSY_LD) && !drop_q && !clear) begin
            ld_done <= 1'b1;
            ld_data <= mc_rdata;
          end
          if ((state == S_BUSY_IF) && !drop_q && !clear) begin
            if_ok   <= 1'b1;
            if_data <= mc_rdata;
            if_pc   <= mc_addr;
          end
        end
      end
    end
  end

endmodule
